// File: rtl/multi_seq_detect_pkg.sv
// seq_detect_pkg: shared defaults, slot config type and width helpers for multi_seq_detect
package seq_detect_pkg;

    localparam int DEF_W    = 8;
    localparam int DEF_P    = 4;
    localparam int DEF_CNTW = 8;
    localparam int DEF_LW   = $clog2(DEF_W + 1);

    function automatic int len_width(input int w);
        return $clog2(w + 1);
    endfunction

    function automatic int idx_width(input int p);
        return (p > 1) ? $clog2(p) : 1;
    endfunction

    typedef struct packed {
        logic [DEF_W-1:0]  seq;
        logic [DEF_LW-1:0] len;
        logic              en;
        logic              nonovl;
    } pat_cfg_t;

endpackage

// File: rtl/multi_seq_detect_seq_slot.sv
// seq_slot: one programmable pattern slot (cfg register, fill counter, compare, hit flop, saturating counter)
//   accept_i  bit accepted on this edge (a_valid and not flush)
//   flush_i   clears the fill counter
//   sh_d_i    shift register contents after this edge's shift
//   cfg_*_i   slot configuration write (cfg_we_i already decoded for this slot)
//   clr_cnt_i clears the match counter, wins over a simultaneous hit
//   match_o   unregistered match for the shared hit_any/hit_idx encoder
//   hit_o     registered one-cycle match pulse
//   cnt_o     saturating match counter
module seq_slot
    import seq_detect_pkg::*;
#(
    parameter  int W    = DEF_W,
    parameter  int CNTW = DEF_CNTW,
    localparam int LW   = len_width(W)
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            accept_i,
    input  logic            flush_i,
    input  logic [W-1:0]    sh_d_i,
    input  logic            cfg_we_i,
    input  logic [W-1:0]    cfg_seq_i,
    input  logic [LW-1:0]   cfg_len_i,
    input  logic            cfg_en_i,
    input  logic            cfg_nonovl_i,
    input  logic            clr_cnt_i,
    output logic            match_o,
    output logic            hit_o,
    output logic [CNTW-1:0] cnt_o
);

    typedef struct packed {
        logic [W-1:0]  seq;
        logic [LW-1:0] len;
        logic          en;
        logic          nonovl;
    } slot_cfg_t;

    slot_cfg_t       cfg_q, cfg_d;
    logic [LW-1:0]   fill_q, fill_d, fill_inc;
    logic            hit_q;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic            len_ok;
    logic [W-1:0]    mask;

    // only the low len bits of the pattern take part in the compare
    assign mask     = ~({W{1'b1}} << cfg_q.len);
    assign len_ok   = (cfg_q.len != '0) && (cfg_q.len <= LW'(W));
    assign fill_inc = (fill_q == LW'(W)) ? fill_q : fill_q + LW'(1);
    // a config write on this edge suppresses the hit for this slot
    assign match_o  = accept_i && !cfg_we_i && cfg_q.en && len_ok &&
                      (fill_inc >= cfg_q.len) && (((sh_d_i ^ cfg_q.seq) & mask) == '0);

    always_comb begin
        cfg_d  = cfg_we_i ? slot_cfg_t'{seq: cfg_seq_i, len: cfg_len_i, en: cfg_en_i, nonovl: cfg_nonovl_i} : cfg_q;
        fill_d = (flush_i || cfg_we_i) ? '0 :
                 !accept_i              ? fill_q :
                 (match_o && cfg_q.nonovl) ? '0 : fill_inc;
        cnt_d  = clr_cnt_i ? '0 : (match_o && !(&cnt_q)) ? cnt_q + CNTW'(1) : cnt_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cfg_q  <= '0;
            fill_q <= '0;
            hit_q  <= 1'b0;
            cnt_q  <= '0;
        end else begin
            cfg_q  <= cfg_d;
            fill_q <= fill_d;
            hit_q  <= match_o;
            cnt_q  <= cnt_d;
        end
    end

    assign hit_o = hit_q;
    assign cnt_o = cnt_q;

endmodule

// File: rtl/multi_seq_detect.sv
// multi_seq_detect: serial multi-pattern sequence detector with per-slot overlap mode and saturating counters
//   a/a_valid   serial bit and its qualifier
//   flush       clears shift history and all fill counters (wins over an accepted bit)
//   cfg_*       write of one pattern slot selected by cfg_idx
//   clr_cnt     synchronous clear of all match counters
//   hit         per-slot registered match pulse; hit_any/hit_idx summarise it
//   match_cnt   slot i counter at [i*CNTW +: CNTW]
module multi_seq_detect
    import seq_detect_pkg::*;
#(
    parameter  int W    = DEF_W,
    parameter  int P    = DEF_P,
    parameter  int CNTW = DEF_CNTW,
    localparam int LW   = len_width(W),
    localparam int IW   = idx_width(P)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              a,
    input  logic              a_valid,
    input  logic              flush,
    input  logic              cfg_we,
    input  logic [IW-1:0]     cfg_idx,
    input  logic [W-1:0]      cfg_seq,
    input  logic [LW-1:0]     cfg_len,
    input  logic              cfg_en,
    input  logic              cfg_nonovl,
    input  logic              clr_cnt,
    output logic [P-1:0]      hit,
    output logic              hit_any,
    output logic [IW-1:0]     hit_idx,
    output logic [P*CNTW-1:0] match_cnt
);

    logic [W-1:0]  sh_q, sh_d;
    logic          accept;
    logic [P-1:0]  match;
    logic          hit_any_q;
    logic [IW-1:0] hit_idx_q, hit_idx_d;

    assign accept = a_valid && !flush;
    assign sh_d   = flush ? '0 : a_valid ? {sh_q[W-2:0], a} : sh_q;

    genvar i;
    generate
        for (i = 0; i < P; i++) begin : g_slot
            seq_slot #(.W(W), .CNTW(CNTW)) u_slot (
                .clk          (clk),
                .reset_n      (reset_n),
                .accept_i     (accept),
                .flush_i      (flush),
                .sh_d_i       (sh_d),
                .cfg_we_i     (cfg_we && (cfg_idx == IW'(i))),
                .cfg_seq_i    (cfg_seq),
                .cfg_len_i    (cfg_len),
                .cfg_en_i     (cfg_en),
                .cfg_nonovl_i (cfg_nonovl),
                .clr_cnt_i    (clr_cnt),
                .match_o      (match[i]),
                .hit_o        (hit[i]),
                .cnt_o        (match_cnt[i*CNTW +: CNTW])
            );
        end
    endgenerate

    // lowest set index wins; scanning downward lets the lowest overwrite last
    always_comb begin
        hit_idx_d = '0;
        for (int k = P - 1; k >= 0; k--)
            if (match[k]) hit_idx_d = IW'(k);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sh_q      <= '0;
            hit_any_q <= 1'b0;
            hit_idx_q <= '0;
        end else begin
            sh_q      <= sh_d;
            hit_any_q <= |match;
            hit_idx_q <= hit_idx_d;
        end
    end

    assign hit_any = hit_any_q;
    assign hit_idx = hit_idx_q;

endmodule
